// File: rtl/trace_pkg.sv
// Shared types and default widths for the trace playback block.
// The record struct is sized to the default widths.
package trace_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int DELTA_W_DEF = 16;
   localparam int TIME_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } player_state_e;

   typedef struct packed {
      logic [DELTA_W_DEF-1:0] delta;
      logic [WIDTH_DEF-1:0]   value;
      logic                   last;
   } trace_rec_t;

endpackage

// File: rtl/trace_hold_reg.sv
// Single-entry record holding register. Accumulates absolute target times and
// decides each cycle whether a record is due to be applied.
module trace_hold_reg
   import trace_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DELTA_W = DELTA_W_DEF,
   parameter int TIME_W  = TIME_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               run_i,
   input  logic               rec_valid_i,
   input  logic [DELTA_W-1:0] rec_delta_i,
   input  logic [WIDTH-1:0]   rec_value_i,
   input  logic               rec_last_i,
   input  logic [TIME_W-1:0]  time_now_i,
   output logic               rec_ready_o,
   output logic               apply_o,
   output logic [WIDTH-1:0]   apply_value_o,
   output logic               apply_last_o,
   output logic               apply_late_o
);

   logic              hold_valid_q, hold_valid_d;
   logic [TIME_W-1:0] hold_target_q, hold_target_d;
   logic [WIDTH-1:0]  hold_value_q, hold_value_d;
   logic              hold_last_q, hold_last_d;
   logic [TIME_W-1:0] target_q, target_d;

   logic [TIME_W-1:0] in_target, hold_diff, in_diff;
   logic              hold_apply, accept, bypass;

   // Due test is modular: a non-negative difference means the target is reached.
   assign in_target  = target_q + TIME_W'(rec_delta_i);
   assign hold_diff  = time_now_i - hold_target_q;
   assign in_diff    = time_now_i - in_target;
   assign hold_apply = run_i && hold_valid_q && !hold_diff[TIME_W-1];

   assign rec_ready_o = run_i && !reset && (!hold_valid_q || hold_apply)
                        && !(hold_apply && hold_last_q);
   assign accept      = rec_valid_i && rec_ready_o;

   // A record arriving into an empty holder at or past its target is applied
   // straight away, so an on-time arrival still meets the one-cycle latency.
   assign bypass = accept && !hold_valid_q && !in_diff[TIME_W-1];

   assign apply_o       = hold_apply || bypass;
   assign apply_value_o = hold_apply ? hold_value_q : rec_value_i;
   assign apply_last_o  = hold_apply ? hold_last_q  : rec_last_i;
   assign apply_late_o  = hold_apply ? (hold_diff != '0) : (bypass && (in_diff != '0));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      hold_valid_d  = hold_valid_q;
      hold_target_d = hold_target_q;
      hold_value_d  = hold_value_q;
      hold_last_d   = hold_last_q;
      target_d      = target_q;
      if (clear_i) begin
         hold_valid_d = 1'b0;
         target_d     = '0;
      end else begin
         if (accept) begin
            target_d = in_target;
         end
         if (accept && !bypass) begin
            hold_valid_d  = 1'b1;
            hold_target_d = in_target;
            hold_value_d  = rec_value_i;
            hold_last_d   = rec_last_i;
         end else if (hold_apply) begin
            hold_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: the payload fields are a single entry, so resetting them is cheap and keeps sim X-free.
      if (reset) begin
         hold_valid_q  <= 1'b0;
         hold_target_q <= '0;
         hold_value_q  <= '0;
         hold_last_q   <= 1'b0;
         target_q      <= '0;
      end else begin
         hold_valid_q  <= hold_valid_d;
         hold_target_q <= hold_target_d;
         hold_value_q  <= hold_value_d;
         hold_last_q   <= hold_last_d;
         target_q      <= target_d;
      end
   end

endmodule

// File: rtl/trace_player.sv
// Replays a stream of (delta, value) records onto wave_out on the recorded cycle.
// Owns the playback FSM, the timeline counter and the registered outputs.
module trace_player
   import trace_pkg::*;
#(
   parameter int               WIDTH   = WIDTH_DEF,
   parameter int               DELTA_W = DELTA_W_DEF,
   parameter int               TIME_W  = TIME_W_DEF,
   parameter logic [WIDTH-1:0] INIT    = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               rec_valid,
   output logic               rec_ready,
   input  logic [DELTA_W-1:0] rec_delta,
   input  logic [WIDTH-1:0]   rec_value,
   input  logic               rec_last,
   output logic [WIDTH-1:0]   wave_out,
   output logic               wave_strobe,
   output logic               busy,
   output logic               done,
   output logic               late_err,
   output logic [TIME_W-1:0]  time_now
);

   player_state_e     state_q, state_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [WIDTH-1:0]  wave_q, wave_d;
   logic              strobe_q, strobe_d;
   logic              late_q, late_d;

   logic              clear, run;
   logic              apply, apply_last, apply_late;
   logic [WIDTH-1:0]  apply_value;

   assign run = (state_q == RUN);

   trace_hold_reg #(
      .WIDTH   (WIDTH),
      .DELTA_W (DELTA_W),
      .TIME_W  (TIME_W)
   ) u_hold (
      .clock         (clock),
      .reset         (reset),
      .clear_i       (clear),
      .run_i         (run),
      .rec_valid_i   (rec_valid),
      .rec_delta_i   (rec_delta),
      .rec_value_i   (rec_value),
      .rec_last_i    (rec_last),
      .time_now_i    (time_q),
      .rec_ready_o   (rec_ready),
      .apply_o       (apply),
      .apply_value_o (apply_value),
      .apply_last_o  (apply_last),
      .apply_late_o  (apply_late)
   );

   always_comb begin
      state_d  = state_q;
      time_d   = time_q;
      wave_d   = wave_q;
      strobe_d = 1'b0;
      late_d   = late_q;
      clear    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               time_d  = '0;
               late_d  = 1'b0;
               clear   = 1'b1;
            end
         end
         RUN: begin
            time_d = time_q + TIME_W'(1);
            if (apply && apply_last) begin
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (apply) begin
         wave_d   = apply_value;
         strobe_d = 1'b1;
         if (apply_late) begin
            late_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         time_q   <= '0;
         wave_q   <= INIT;
         strobe_q <= 1'b0;
         late_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         wave_q   <= wave_d;
         strobe_q <= strobe_d;
         late_q   <= late_d;
      end
   end

   assign wave_out    = wave_q;
   assign wave_strobe = strobe_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == FINISH);
   assign late_err    = late_q;
   assign time_now    = time_q;

endmodule

// File: tb/tb_trace_player.sv
// Bench for trace_player: expected strobes are queued as records are driven
// and popped by a monitor whenever wave_strobe fires.
module tb_trace_player;
   import trace_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rec_valid = 1'b0;
   logic        rec_ready;
   logic [15:0] rec_delta = '0;
   logic [7:0]  rec_value = '0;
   logic        rec_last = 1'b0;
   logic [7:0]  wave_out;
   logic        wave_strobe;
   logic        busy;
   logic        done;
   logic        late_err;
   logic [31:0] time_now;

   localparam logic [7:0] INIT_VAL = 8'hC3;

   typedef struct {
      logic [7:0]  value;
      logic [31:0] t;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_checks = 0;
   int   n_pass   = 0;

   trace_player #(
      .WIDTH   (8),
      .DELTA_W (16),
      .TIME_W  (32),
      .INIT    (INIT_VAL)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_delta   (rec_delta),
      .rec_value   (rec_value),
      .rec_last    (rec_last),
      .wave_out    (wave_out),
      .wave_strobe (wave_strobe),
      .busy        (busy),
      .done        (done),
      .late_err    (late_err),
      .time_now    (time_now)
   );

   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog expired at time_now=%0d", time_now);
      $fatal(1, "watchdog");
   end

   // Every strobe must match the oldest outstanding expectation in value and time.
   always @(negedge clock) begin
      if (!reset && wave_strobe) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_strobe got value %h at time_now %0d, want no strobe",
                     wave_out, time_now);
         end else begin
            e_mon = exp_q.pop_front();
            if (wave_out !== e_mon.value || time_now !== e_mon.t)
               $display("FAIL strobe got value %h at time_now %0d, want %h at %0d",
                        wave_out, time_now, e_mon.value, e_mon.t);
            else n_pass++;
         end
      end
   end

   function automatic trace_rec_t mk(input logic [15:0] d, input logic [7:0] v, input logic l);
      trace_rec_t r;
      r.delta = d;
      r.value = v;
      r.last  = l;
      return r;
   endfunction

   function automatic void expect_strobe(input logic [7:0] v, input logic [31:0] t);
      exp_t e;
      e.value = v;
      e.t     = t;
      exp_q.push_back(e);
   endfunction

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Offers a record once time_now reaches min_time, holding it until the handshake edge.
   task automatic send(input trace_rec_t r, input int min_time);
      int budget;
      @(negedge clock);
      budget = 0;
      rec_valid = 1'b0;
      while (time_now < 32'(min_time) && budget < 500) begin
         @(negedge clock);
         budget++;
      end
      rec_delta = r.delta;
      rec_value = r.value;
      rec_last  = r.last;
      rec_valid = 1'b1;
      budget = 0;
      while (!rec_ready && budget < 500) begin
         @(negedge clock);
         budget++;
      end
      if (!rec_ready) begin
         n_checks++;
         $display("FAIL send_timeout got rec_ready %b, want 1 within 500 cycles", rec_ready);
      end else begin
         @(posedge clock);
      end
      #1 rec_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic [31:0] exp_time,
                            input logic [7:0] exp_val, input logic exp_late,
                            input logic poke_start);
      int budget = 0;
      @(negedge clock);
      while (!done && budget < 500) begin
         @(negedge clock);
         budget++;
      end
      n_checks++;
      if (done !== 1'b1 || time_now !== exp_time || wave_out !== exp_val || late_err !== exp_late)
         $display("FAIL %s_done got done=%b t=%0d wave=%h late=%b, want 1 t=%0d wave=%h late=%b",
                  name, done, time_now, wave_out, late_err, exp_time, exp_val, exp_late);
      else n_pass++;
      if (poke_start) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0)
         $display("FAIL %s_idle got busy=%b done=%b pending=%0d, want 0 0 0",
                  name, busy, done, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (wave_out !== INIT_VAL) $display("FAIL reset_wave got %h want %h", wave_out, INIT_VAL);
      else n_pass++;
      n_checks++;
      if ({wave_strobe, busy, done, late_err, rec_ready} !== 5'b0)
         $display("FAIL reset_flags got %b want 00000", {wave_strobe, busy, done, late_err, rec_ready});
      else n_pass++;
      n_checks++;
      if (time_now !== 32'd0) $display("FAIL reset_time got %0d want 0", time_now);
      else n_pass++;
   endtask

   task automatic test_basic();
      expect_strobe(8'hA5, 32'd4);
      expect_strobe(8'h3C, 32'd6);
      pulse_start();
      send(mk(16'd3, 8'hA5, 1'b0), 0);
      send(mk(16'd2, 8'h3C, 1'b1), 0);
      wait_done("basic", 32'd6, 8'h3C, 1'b0, 1'b0);
   endtask

   task automatic test_delta_zero();
      expect_strobe(8'h11, 32'd1);
      pulse_start();
      send(mk(16'd0, 8'h11, 1'b1), 0);
      wait_done("delta0", 32'd1, 8'h11, 1'b0, 1'b0);
   endtask

   task automatic test_late();
      expect_strobe(8'h55, 32'd3);
      expect_strobe(8'h66, 32'd7);
      pulse_start();
      send(mk(16'd2, 8'h55, 1'b0), 0);
      send(mk(16'd1, 8'h66, 1'b1), 6);
      wait_done("late", 32'd7, 8'h66, 1'b1, 1'b0);
      repeat (3) @(negedge clock);
      n_checks++;
      if (late_err !== 1'b1) $display("FAIL late_sticky got %b want 1", late_err);
      else n_pass++;
   endtask

   task automatic test_restart();
      pulse_start();
      @(negedge clock);
      n_checks++;
      if (time_now !== 32'd0 || late_err !== 1'b0 || busy !== 1'b1)
         $display("FAIL restart got t=%0d late=%b busy=%b, want 0 0 1", time_now, late_err, busy);
      else n_pass++;
      expect_strobe(8'h99, 32'd5);
      send(mk(16'd4, 8'h99, 1'b1), 0);
      wait_done("restart", 32'd5, 8'h99, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignored();
      expect_strobe(8'h21, 32'd6);
      expect_strobe(8'h42, 32'd11);
      pulse_start();
      send(mk(16'd5, 8'h21, 1'b0), 0);
      pulse_start();
      @(negedge clock);
      n_checks++;
      if (time_now !== 32'd2 || busy !== 1'b1)
         $display("FAIL start_in_run got t=%0d busy=%b, want 2 1", time_now, busy);
      else n_pass++;
      send(mk(16'd5, 8'h42, 1'b1), 0);
      wait_done("start_ign", 32'd11, 8'h42, 1'b0, 1'b1);
   endtask

   task automatic test_reset_busy();
      expect_strobe(8'h31, 32'd5);
      pulse_start();
      send(mk(16'd3, 8'h31, 1'b0), 4);
      send(mk(16'd20, 8'h32, 1'b0), 0);
      @(negedge clock);
      n_checks++;
      if (late_err !== 1'b1 || busy !== 1'b1)
         $display("FAIL pre_reset got late=%b busy=%b, want 1 1", late_err, busy);
      else n_pass++;
      rec_valid = 1'b1;
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      rec_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (wave_out !== INIT_VAL || busy !== 1'b0 || rec_ready !== 1'b0 || late_err !== 1'b0 || time_now !== 32'd0)
         $display("FAIL mid_reset got wave=%h busy=%b ready=%b late=%b t=%0d, want %h 0 0 0 0",
                  wave_out, busy, rec_ready, late_err, time_now, INIT_VAL);
      else n_pass++;
      repeat (30) @(negedge clock);
      n_checks++;
      if (wave_out !== INIT_VAL || busy !== 1'b0)
         $display("FAIL after_reset got wave=%h busy=%b, want %h 0", wave_out, busy, INIT_VAL);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) expect_strobe(8'h10 + 8'(i), 32'(i + 2));
      pulse_start();
      for (int i = 0; i < 6; i++) send(mk(16'd1, 8'h10 + 8'(i), i == 5), 0);
      wait_done("b2b", 32'd7, 8'h15, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delta_zero();
      test_late();
      test_restart();
      test_start_ignored();
      test_reset_busy();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
